// File: rtl/eco32_core_jpu_mt_if.sv
// Jump-unit bus: upstream issue, MPU flow handshake, CR table writes and results.
interface eco32_core_jpu_mt_if #(
  parameter int TID_W = 1,
  parameter int CR_AW = 4
);
  logic             i_stb;
  logic [TID_W-1:0] i_tid;
  logic [3:0]       i_asid;
  logic [1:0]       i_pid;
  logic             i_evt_req;
  logic [11:0]      i_jp_cw;
  logic [31:0]      i_r0_data;
  logic [31:0]      i_r2_data;

  logic             fci_inst_lsf;
  logic             fci_inst_skip;
  logic             fci_inst_rep;
  logic             fco_inst_jpf;

  logic [1:0]       jcr_wen;
  logic [TID_W-1:0] jcr_tid;
  logic [CR_AW-1:0] jcr_addr;
  logic [31:0]      jcr_dataL;
  logic [31:0]      jcr_dataH;

  logic             o_stb;
  logic             o_evt_ack;
  logic [TID_W-1:0] o_tid;
  logic [3:0]       o_asid;
  logic [1:0]       o_pid;
  logic [15:0]      o_isw;
  logic [31:0]      o_v_addr;
  logic             o_flt_stb;
  logic [1:0]       o_flt_code;
  logic             o_busy;

  modport master (
    output i_stb, i_tid, i_asid, i_pid, i_evt_req, i_jp_cw, i_r0_data, i_r2_data,
    output fci_inst_lsf, fci_inst_skip, fci_inst_rep,
    output jcr_wen, jcr_tid, jcr_addr, jcr_dataL, jcr_dataH,
    input  fco_inst_jpf, o_stb, o_evt_ack, o_tid, o_asid, o_pid, o_isw, o_v_addr,
    input  o_flt_stb, o_flt_code, o_busy
  );

  modport slave (
    input  i_stb, i_tid, i_asid, i_pid, i_evt_req, i_jp_cw, i_r0_data, i_r2_data,
    input  fci_inst_lsf, fci_inst_skip, fci_inst_rep,
    input  jcr_wen, jcr_tid, jcr_addr, jcr_dataL, jcr_dataH,
    output fco_inst_jpf, o_stb, o_evt_ack, o_tid, o_asid, o_pid, o_isw, o_v_addr,
    output o_flt_stb, o_flt_code, o_busy
  );
endinterface

// File: rtl/eco32_core_jpu_mt.sv
// Multi-thread jump unit: CR/GP target generation, fault detection and an
// MPU-driven replay loop that reissues a buffered jump up to REP_MAX times.
module eco32_core_jpu_mt #(
  parameter int TID_W   = 1,
  parameter int CR_AW   = 4,
  parameter int REP_MAX = 3
) (
  input  logic               clk,
  input  logic               rst,
  eco32_core_jpu_mt_if.slave bus
);
  localparam int IW   = TID_W + CR_AW;
  localparam int NENT = 2 ** IW;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [3:0]       asid;
    logic             evt;
    logic [11:0]      cw;
    logic [31:0]      r0;
    logic [31:0]      r2;
  } req_t;

  typedef enum logic [1:0] {IDLE, HOLD, REPLAY} state_t;

  logic [31:0]     cra_mem [NENT];
  logic [31:0]     crb_mem [NENT];
  logic [NENT-1:0] cra_vld;

  state_t      state;
  logic [3:0]  rep_cnt;
  req_t        in_req, a0_req, b1_req, buf_req;
  logic        a0_stb, b1_stb;
  logic        busy, stb, evt_ack, flt_stb;
  logic [1:0]  flt_code;
  logic [31:0] v_addr;
  logic [15:0] isw;
  logic [TID_W-1:0] tid_q;
  logic [3:0]  asid_q;
  logic [1:0]  pid_q;

  logic [IW-1:0] widx, ridx;
  logic [31:0]   cra_rd, crb_rd, base, offs, target;
  logic          cre, vld, flt_inv, flt_mis, kill;

  assign widx = {bus.jcr_tid, bus.jcr_addr};

  always_ff @(posedge clk) begin
    if (bus.jcr_wen[0]) cra_mem[widx] <= bus.jcr_dataL;
    if (bus.jcr_wen[1]) crb_mem[widx] <= bus.jcr_dataH;
  end

  always_comb begin
    in_req.tid  = bus.i_tid;
    in_req.asid = bus.i_asid;
    in_req.evt  = bus.i_evt_req;
    in_req.cw   = bus.i_jp_cw;
    in_req.r0   = bus.i_r0_data;
    in_req.r2   = bus.i_r2_data;
    if (state == REPLAY) begin
      a0_req = buf_req;
      a0_stb = 1'b1;
    end else begin
      a0_req = in_req;
      a0_stb = bus.i_stb & bus.i_jp_cw[0] & ~b1_stb & ~busy;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_stb <= 1'b0;
      b1_req <= '0;
    end else begin
      b1_stb <= a0_stb;
      if (a0_stb) b1_req <= a0_req;
    end
  end

  // Table read is asynchronous, so a same-cycle write lands after this read.
  assign ridx    = {b1_req.tid, b1_req.cw[CR_AW+6:7]};
  assign cra_rd  = cra_mem[ridx];
  assign crb_rd  = crb_mem[ridx];
  assign vld     = cra_vld[ridx];
  assign cre     = b1_req.cw[4];
  assign base    = b1_req.cw[11] ? {cra_rd[31:3], 3'b000} : {cra_rd[31:2], 2'b00};
  assign offs    = (b1_req.cw[4] & b1_req.cw[3]) ? {19'd0, b1_req.r2[9:0], 3'b000} : b1_req.r2;
  assign target  = (cre ? base : b1_req.r0) + offs;
  assign flt_inv = cre & ~vld;
  assign flt_mis = ~cre & (b1_req.cw[11] ? (|target[2:0]) : (|target[1:0]));
  assign kill    = bus.fci_inst_lsf | bus.fci_inst_skip;

  // state  | meaning
  // IDLE   | accepting new jumps, evaluating the b1 attempt
  // HOLD   | replay requested; jump parked in buf_req, upstream stalled
  // REPLAY | buffered jump is re-injected into a0 this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rep_cnt  <= 4'd0;
      buf_req  <= '0;
      busy     <= 1'b0;
      stb      <= 1'b0;
      evt_ack  <= 1'b0;
      flt_stb  <= 1'b0;
      flt_code <= 2'b00;
      v_addr   <= 32'd0;
      isw      <= 16'd0;
      tid_q    <= '0;
      asid_q   <= 4'd0;
      pid_q    <= 2'b00;
      cra_vld  <= '0;
    end else begin
      stb     <= 1'b0;
      evt_ack <= 1'b0;
      flt_stb <= 1'b0;
      if (bus.jcr_wen[0]) cra_vld[widx] <= 1'b1;

      case (state)
        HOLD:    state <= REPLAY;
        REPLAY: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (b1_stb) begin
        if (kill) begin
          rep_cnt <= 4'd0;
        end else if (flt_inv | flt_mis) begin
          flt_stb  <= 1'b1;
          flt_code <= flt_inv ? 2'b01 : 2'b10;
          rep_cnt  <= 4'd0;
        end else if (bus.fci_inst_rep) begin
          if (rep_cnt == 4'(REP_MAX)) begin
            flt_stb  <= 1'b1;
            flt_code <= 2'b11;
            rep_cnt  <= 4'd0;
          end else begin
            buf_req <= b1_req;
            rep_cnt <= rep_cnt + 4'd1;
            state   <= HOLD;
            busy    <= 1'b1;
          end
        end else begin
          stb     <= 1'b1;
          evt_ack <= b1_req.evt;
          v_addr  <= target;
          isw     <= cre ? crb_rd[15:0] : 16'd0;
          tid_q   <= b1_req.tid;
          asid_q  <= b1_req.asid;
          pid_q   <= b1_req.cw[2:1];
          rep_cnt <= 4'd0;
        end
      end
    end
  end

  assign bus.o_stb        = stb;
  assign bus.fco_inst_jpf = stb;
  assign bus.o_evt_ack    = evt_ack;
  assign bus.o_flt_stb    = flt_stb;
  assign bus.o_flt_code   = flt_code;
  assign bus.o_busy       = busy;
  assign bus.o_v_addr     = v_addr;
  assign bus.o_isw        = isw;
  assign bus.o_tid        = tid_q;
  assign bus.o_asid       = asid_q;
  assign bus.o_pid        = pid_q;

  // pid comes from the control word; upstream i_pid is informational only.
  logic unused_ok;
  assign unused_ok = ^{bus.i_pid, b1_req.cw[6:5], b1_req.cw[0], crb_rd[31:16]};
endmodule

// File: doc/eco32_core_jpu_mt.md
ECO32_CORE_JPU_MT -- requirements
Module: eco32_core_jpu_mt

Interface
REQ-001 SHALL have parameter TID_W, default 1: thread-id width; the table holds 2**TID_W threads.
REQ-002 SHALL have parameter CR_AW, default 4: entry-address width; the table holds 2**CR_AW entries per thread.
REQ-003 SHALL have parameter REP_MAX, default 3: number of consecutive replays tolerated per jump, range 1..15.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock; reset is asynchronous and active-high.
REQ-005 SHALL have upstream inputs:
- i_stb (1), i_tid (TID_W), i_asid (4), i_pid (2), i_evt_req (1).
- i_jp_cw (12): [0] jump enable, [2:1] pid, [3] eid-register mode, [4] CR mode, [CR_AW+6:7] entry index, [11] 8-byte base alignment.
- i_r0_data (32): GP base; i_r2_data (32): offset.
REQ-006 SHALL have MPU flow inputs fci_inst_lsf, fci_inst_skip and fci_inst_rep (each 1), and output fco_inst_jpf (1).
REQ-007 SHALL have table-write inputs jcr_wen (2), jcr_tid (TID_W), jcr_addr (CR_AW), jcr_dataL (32) and jcr_dataH (32).
REQ-008 SHALL have outputs:
- o_stb (1), o_evt_ack (1), o_tid (TID_W), o_asid (4), o_pid (2), o_isw (16), o_v_addr (32).
- o_flt_stb (1) and o_flt_code (2).
- o_busy (1): upstream must hold i_stb low while o_busy is high.

Function
REQ-009 SHALL store the table in two arrays, CRA and CRB, each 2**(TID_W+CR_AW) x 32, with asynchronous read and synchronous write.
REQ-010 SHALL write CRA and set the entry's valid bit on jcr_wen[0], and write CRB on jcr_wen[1]; when a write and a read hit the same entry in the same cycle, the read SHALL return the old data.
REQ-011 SHALL register stage a0 from the inputs, or from the replay buffer when the state is REPLAY; a0_stb = i_stb & i_jp_cw[0] & !b1_stb & !o_busy.
REQ-012 SHALL form the CR base in a0 as CRA[31:3],000 when cw[11] is 1, and as CRA[31:2],00 otherwise.
REQ-013 SHALL form the offset in a0 as i_r2_data when cw[4] is 0 or cw[3] is 0, and as zero-extended {r2[9:0],000} when cw[4] is 1 and cw[3] is 1.
REQ-014 SHALL compute the b1 target as (cre ? baseCR : r0) + offset, modulo 2**32.
REQ-015 SHALL drive the b1 outputs as follows:
- o_isw = cre ? CRB[15:0] : 0.
- o_asid = i_asid, o_pid = cw[2:1], o_tid = the a0 tid.
REQ-016 SHALL raise o_stb and fco_inst_jpf one cycle after a0 when a0_stb & !lsf & !skip & !rep & !fault; the latency from i_stb to o_stb is 2 cycles.
REQ-017 SHALL raise o_evt_ack together with the o_stb conditions plus a0_evt_req, so an event is acknowledged exactly once, never on a replayed attempt.
REQ-018 SHALL detect faults in a0, reported as an o_flt_stb pulse at b1 with o_stb held at 0:
- Code 01: cre and the entry's valid bit is 0.
- Code 10: not cre and the target is misaligned (low 3 bits nonzero when cw[11] is 1, low 2 bits nonzero otherwise).
- Code 11: replay limit exceeded.
- When several apply, the lowest code wins.
REQ-019 SHALL implement a replay FSM with states IDLE, HOLD and REPLAY.
REQ-020 SHALL, in IDLE, on a0_stb & rep & !lsf & !skip, capture all a0 fields into the buffer, increment rep_cnt, and go to HOLD.
REQ-021 SHALL go from HOLD to REPLAY unconditionally.
REQ-022 SHALL, in REPLAY, reload a0 from the buffer with a0_stb = 1, then go to IDLE; if that attempt is replayed again, the FSM re-enters HOLD.
REQ-023 SHALL hold o_busy high in HOLD and REPLAY.
REQ-024 SHALL handle the replay counter as follows:
- rep_cnt clears when an attempt completes, is skipped or faults.
- When rep_cnt reaches REP_MAX and the attempt is replayed again, the FSM SHALL instead emit fault 11, clear rep_cnt and go to IDLE.
REQ-025 SHALL drop the buffered jump with no output when lsf or skip is asserted during a replayed attempt, and return to IDLE.

Reset
REQ-026 SHALL, on rst, asynchronously:
- clear every output and pipeline strobe to 0, and o_v_addr and o_isw to 0;
- set the FSM to IDLE and rep_cnt to 0;
- clear all CRA valid bits.
CRA and CRB contents are not reset.
REQ-027 SHALL, when rst is asserted mid-replay, discard the buffered jump and emit no o_stb or o_flt_stb after rst is released.

Verification
REQ-028 SHALL cover a CR jump: write CRA[t0,e3] = 0x0000_1007 and CRB = 0x0000_00A5, then issue cw[4] = 1, cw[3] = 1, cw[11] = 1, r2 = 2 -> two cycles later o_stb = 1, o_v_addr = 0x0000_1010, o_isw = 0x00A5.
REQ-029 SHALL cover a GP jump: r0 = 0xFFFF_FFFC, r2 = 8, cw[11] = 0 -> o_v_addr = 0x0000_0004 (wrap), o_isw = 0.
REQ-030 SHALL cover an invalid entry after reset: a CR jump to any entry -> o_flt_stb = 1, o_flt_code = 01, o_stb = 0.
REQ-031 SHALL cover a single replay: rep = 1 for one attempt -> o_busy high for 2 cycles, then o_stb = 1 with an identical address, and o_evt_ack asserted exactly once.
REQ-032 SHALL cover the replay limit with REP_MAX = 3: rep held high -> three reissues, then o_flt_code = 11, FSM in IDLE, o_busy = 0.
REQ-033 SHALL cover back-to-back issue: i_stb on consecutive cycles -> the second is dropped (a0_stb = 0 because b1_stb = 1).
